// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: sprinkler/dripper run control with BCD countdown,
// tank refill and conflict fault handling.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   tick                  one-cycle pulse every 10 s (countdown step)
//   low/mid/high_water_level  tank probe levels
//   earth_humidity        1 = soil wet (stop irrigating)
//   air_humidity          1 = air humid (forces dripper mode)
//   low_temperature       1 = cold (forces dripper mode)
//   restart               one-cycle pulse, reload current mode duration
//   splinker_bomb         sprinkler pump, on in SPRINKLE
//   dripper_valvule       dripper valve, open in DRIP
//   water_supply_valvule  tank fill valve, open in FILL
//   alarm                 on in FAULT or FILL
//   state                 current FSM state code
//   minutes_d/minutes_u/seconds_d  BCD countdown (min tens, min units, 10 s)
module irrigation_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  input  logic       restart,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       water_supply_valvule,
  output logic       alarm,
  output logic [2:0] state,
  output logic [3:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [3:0] seconds_d
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPRINKLE = 3'd1,
    DRIP     = 3'd2,
    HOLD     = 3'd3,
    FILL     = 3'd4,
    FAULT    = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] md_q, md_d;
  logic [3:0] mu_q, mu_d;
  logic [3:0] sd_q, sd_d;
  logic [1:0] hc_q, hc_d;
  logic       bomb_q, drip_q, fill_q, alarm_q;

  logic       conflict;
  logic       sprinkler_mode;

  // One BCD step down of the current timer value
  logic [3:0] dec_md, dec_mu, dec_sd;
  logic       cur_zero, dec_zero;

  // Duration of the mode implied by the current inputs
  logic [3:0] ld_md, ld_mu;

  assign conflict = (high_water_level & ~mid_water_level)
                  | (mid_water_level & ~low_water_level);

  assign sprinkler_mode = ~air_humidity & ~low_temperature
                        & mid_water_level;

  always_comb begin
    dec_md = md_q;
    dec_mu = mu_q;
    dec_sd = sd_q;
    if (sd_q != 4'd0) begin
      dec_sd = sd_q - 4'd1;
    end else begin
      dec_sd = 4'd5;
      if (mu_q != 4'd0) begin
        dec_mu = mu_q - 4'd1;
      end else begin
        dec_mu = 4'd9;
        if (md_q != 4'd0) dec_md = md_q - 4'd1;
      end
    end
  end

  assign cur_zero = (md_q == 4'd0) && (mu_q == 4'd0)
                 && (sd_q == 4'd0);
  assign dec_zero = (dec_md == 4'd0) && (dec_mu == 4'd0)
                 && (dec_sd == 4'd0);

  // Sprinkler runs 15:00 (1:5:0), dripper runs 30:00 (3:0:0)
  assign ld_md = sprinkler_mode ? 4'd1 : 4'd3;
  assign ld_mu = sprinkler_mode ? 4'd5 : 4'd0;

  always_comb begin
    state_d = state_q;
    md_d    = md_q;
    mu_d    = mu_q;
    sd_d    = sd_q;
    hc_d    = hc_q;

    if (conflict) begin
      state_d = FAULT;
      md_d    = 4'd0;
      mu_d    = 4'd0;
      sd_d    = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!low_water_level) begin
            state_d = FILL;
          end else if (!earth_humidity) begin
            state_d = sprinkler_mode ? SPRINKLE : DRIP;
            md_d    = ld_md;
            mu_d    = ld_mu;
            sd_d    = 4'd0;
          end
        end
        FILL: begin
          if (high_water_level) state_d = IDLE;
        end
        FAULT: begin
          state_d = IDLE;
        end
        SPRINKLE, DRIP: begin
          if (!low_water_level) begin
            state_d = FILL;
            md_d    = 4'd0;
            mu_d    = 4'd0;
            sd_d    = 4'd0;
          end else if (earth_humidity) begin
            state_d = IDLE;
            md_d    = 4'd0;
            mu_d    = 4'd0;
            sd_d    = 4'd0;
          end else if (sprinkler_mode
                       != (state_q == SPRINKLE)) begin
            state_d = sprinkler_mode ? SPRINKLE : DRIP;
            md_d    = ld_md;
            mu_d    = ld_mu;
            sd_d    = 4'd0;
          end else if (restart) begin
            md_d    = ld_md;
            mu_d    = ld_mu;
            sd_d    = 4'd0;
          end else if (tick) begin
            // A zero timer here would be unreachable; never wrap below it
            if (cur_zero) begin
              state_d = HOLD;
              hc_d    = 2'd0;
            end else begin
              md_d = dec_md;
              mu_d = dec_mu;
              sd_d = dec_sd;
              if (dec_zero) begin
                state_d = HOLD;
                hc_d    = 2'd0;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (hc_q == 2'd2) state_d = IDLE;
            else              hc_d    = hc_q + 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Actuator outputs are registered from the next state so they
  // line up with the state register on every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      md_q    <= 4'd0;
      mu_q    <= 4'd0;
      sd_q    <= 4'd0;
      hc_q    <= 2'd0;
      bomb_q  <= 1'b0;
      drip_q  <= 1'b0;
      fill_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      mu_q    <= mu_d;
      sd_q    <= sd_d;
      hc_q    <= hc_d;
      bomb_q  <= (state_d == SPRINKLE);
      drip_q  <= (state_d == DRIP);
      fill_q  <= (state_d == FILL);
      alarm_q <= (state_d == FILL) || (state_d == FAULT);
    end
  end

  assign splinker_bomb        = bomb_q;
  assign dripper_valvule      = drip_q;
  assign water_supply_valvule = fill_q;
  assign alarm                = alarm_q;
  assign state                = state_q;
  assign minutes_d            = md_q;
  assign minutes_u            = mu_q;
  assign seconds_d            = sd_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Testbench for irrigation_sequencer: directed scenarios plus
// randomized stimulus against a countdown-in-ticks reference model.
module tb_irrigation_sequencer;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       low_water_level;
  logic       mid_water_level;
  logic       high_water_level;
  logic       earth_humidity;
  logic       air_humidity;
  logic       low_temperature;
  logic       restart;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       water_supply_valvule;
  logic       alarm;
  logic [2:0] state;
  logic [3:0] minutes_d;
  logic [3:0] minutes_u;
  logic [3:0] seconds_d;

  int n_chk;
  int n_fail;

  // Reference: state code, remaining time in 10 s ticks, hold ticks seen
  int m_st;
  int m_t;
  int m_hc;

  irrigation_sequencer dut (
    .clock               (clock),
    .reset               (reset),
    .tick                (tick),
    .low_water_level     (low_water_level),
    .mid_water_level     (mid_water_level),
    .high_water_level    (high_water_level),
    .earth_humidity      (earth_humidity),
    .air_humidity        (air_humidity),
    .low_temperature     (low_temperature),
    .restart             (restart),
    .splinker_bomb       (splinker_bomb),
    .dripper_valvule     (dripper_valvule),
    .water_supply_valvule(water_supply_valvule),
    .alarm               (alarm),
    .state               (state),
    .minutes_d           (minutes_d),
    .minutes_u           (minutes_u),
    .seconds_d           (seconds_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit conf, sm, in_spr;
    conf = (high_water_level && !mid_water_level)
        || (mid_water_level && !low_water_level);
    sm = !air_humidity && !low_temperature && mid_water_level;
    if (reset) begin
      m_st = 0; m_t = 0; m_hc = 0;
    end else if (conf) begin
      m_st = 5; m_t = 0;
    end else begin
      case (m_st)
        0: begin
          if (!low_water_level) m_st = 4;
          else if (!earth_humidity) begin
            m_st = sm ? 1 : 2;
            m_t  = sm ? 90 : 180;
          end
        end
        4: if (high_water_level) m_st = 0;
        5: m_st = 0;
        1, 2: begin
          in_spr = (m_st == 1);
          if (!low_water_level) begin
            m_st = 4; m_t = 0;
          end else if (earth_humidity) begin
            m_st = 0; m_t = 0;
          end else if (sm != in_spr) begin
            m_st = sm ? 1 : 2;
            m_t  = sm ? 90 : 180;
          end else if (restart) begin
            m_t = sm ? 90 : 180;
          end else if (tick) begin
            if (m_t > 0) m_t--;
            if (m_t == 0) begin
              m_st = 3; m_hc = 0;
            end
          end
        end
        3: begin
          if (tick) begin
            m_hc++;
            if (m_hc == 3) m_st = 0;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    chk("state", int'(state), m_st);
    chk("bomb", int'(splinker_bomb), int'(m_st == 1));
    chk("drip", int'(dripper_valvule), int'(m_st == 2));
    chk("supply", int'(water_supply_valvule), int'(m_st == 4));
    chk("alarm", int'(alarm), int'(m_st == 4 || m_st == 5));
    chk("min_d", int'(minutes_d), m_t / 60);
    chk("min_u", int'(minutes_u), (m_t / 6) % 10);
    chk("sec_d", int'(seconds_d), m_t % 6);
  endtask

  task automatic set_lvl(input bit l, input bit m, input bit h);
    low_water_level  = l;
    mid_water_level  = m;
    high_water_level = h;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  int r;

  initial begin
    n_chk = 0; n_fail = 0;
    m_st = 0; m_t = 0; m_hc = 0;
    reset = 1'b1; tick = 1'b0; restart = 1'b0;
    set_lvl(1, 1, 1);
    earth_humidity = 1'b0;
    air_humidity = 1'b0;
    low_temperature = 1'b0;
    #2;
    cyc();
    cyc();
    chk("rst_state", int'(state), 0);

    // Sprinkler run to HOLD and back round
    reset = 1'b0;
    cyc();
    chk("spr_state", int'(state), 1);
    chk("spr_md", int'(minutes_d), 1);
    chk("spr_mu", int'(minutes_u), 5);
    ticks(90);
    chk("hold_state", int'(state), 3);
    ticks(3);
    chk("hold_idle", int'(state), 0);
    cyc();
    chk("spr_again", int'(state), 1);

    // Mode switch at 1:2:3
    ticks(15);
    chk("t123_mu", int'(minutes_u), 2);
    chk("t123_sd", int'(seconds_d), 3);
    air_humidity = 1'b1;
    cyc();
    chk("sw_drip", int'(dripper_valvule), 1);
    chk("sw_md", int'(minutes_d), 3);

    // Conflict in DRIP, then recovery
    set_lvl(1, 0, 1);
    cyc();
    chk("flt_state", int'(state), 5);
    chk("flt_alarm", int'(alarm), 1);
    set_lvl(1, 1, 1);
    cyc();
    chk("flt_idle", int'(state), 0);
    cyc();

    // Refill from SPRINKLE
    air_humidity = 1'b0;
    cyc();
    chk("back_spr", int'(state), 1);
    set_lvl(0, 0, 0);
    cyc();
    chk("fill_valve", int'(water_supply_valvule), 1);
    cyc();
    set_lvl(1, 1, 1);
    cyc();
    chk("fill_idle", int'(state), 0);
    cyc();
    chk("refill_spr", int'(state), 1);

    // restart + tick at 0:4:2, then reset mid-run
    ticks(64);
    chk("t042_mu", int'(minutes_u), 4);
    chk("t042_sd", int'(seconds_d), 2);
    restart = 1'b1; tick = 1'b1;
    cyc();
    restart = 1'b0; tick = 1'b0;
    chk("rl_mu", int'(minutes_u), 5);
    ticks(7);
    reset = 1'b1;
    cyc();
    chk("rst_mid", int'(state), 0);
    chk("rst_md", int'(minutes_d), 0);
    reset = 1'b0;

    // Randomized operation
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) begin
        r = $urandom_range(0, 11);
        if (r == 0)      set_lvl(0, 0, 0);
        else if (r == 1) set_lvl(1, 0, 0);
        else if (r == 2) set_lvl(1, 1, 0);
        else if (r == 3) set_lvl(0, 1, 0);
        else if (r == 4) set_lvl(1, 0, 1);
        else             set_lvl(1, 1, 1);
      end
      if ($urandom_range(0, 39) == 0)
        earth_humidity = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0)
        air_humidity = ~air_humidity;
      if ($urandom_range(0, 59) == 0)
        low_temperature = ~low_temperature;
      tick    = ($urandom_range(0, 1) == 1);
      restart = ($urandom_range(0, 29) == 0);
      reset   = ($urandom_range(0, 699) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
